conv_relu_maxpool: RTL

//   Post-processing stage directly downstream of conv_simple. Takes the raster-order

---
 rtl/conv_relu_maxpool.sv | 124 ++++++++++++
 1 files changed

// File: rtl/conv_relu_maxpool.sv
// conv_relu_maxpool
//   Post-processing stage that sits directly after the convolution engine.
//   It consumes the raster-order stream of signed convolution results and applies
//   2x2, stride-2 max pooling followed by optional ReLU. For each frame it emits a
//   raster-order pooled map of (OUT_SIZE/2)x(OUT_SIZE/2) values.
//
//   Ports
//     clk           rising-edge clock
//     rst           synchronous, active-high reset
//     i_y           signed conv sample, raster order (row-major)
//     i_valid       i_y is valid this cycle; gaps of any length are allowed
//     o_y           signed pooled result; holds its last value while o_valid=0
//     o_valid       one-cycle pulse per pooled value
//     o_frame_done  high together with o_valid for the last pooled value of a frame
//
//   Handshake: the input is valid-only. Each i_valid=1 cycle is exactly one sample.
//   The output is valid-only with no backpressure, so the consumer must take o_y
//   on every cycle where o_valid=1. The output rate is at most one result per two
//   input samples.
module conv_relu_maxpool #(
  parameter int SUM_BW   = 16,
  parameter int OUT_SIZE = 28,
  parameter int CNT_BW   = 5,
  parameter int RELU_EN  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SUM_BW-1:0] i_y,
  input  logic                     i_valid,
  output logic signed [SUM_BW-1:0] o_y,
  output logic                     o_valid,
  output logic                     o_frame_done
);

  localparam int HALF = OUT_SIZE / 2;
  localparam logic [CNT_BW-1:0] LAST = CNT_BW'(OUT_SIZE - 1);

  logic [CNT_BW-1:0]        col_q, col_d;
  logic [CNT_BW-1:0]        row_q, row_d;
  logic signed [SUM_BW-1:0] hold_q, hold_d;
  logic signed [SUM_BW-1:0] o_y_q, o_y_d;
  logic                     o_valid_q, o_valid_d;
  logic                     o_frame_done_q, o_frame_done_d;

  // One entry per pooling window column. Each entry holds the max of the even-row
  // pair. It is always written on the even row before the odd row reads it, so the
  // buffer needs no reset.
  logic signed [SUM_BW-1:0] rowbuf_q [HALF];
  logic                     rowbuf_we;
  logic signed [SUM_BW-1:0] pair_max;
  logic signed [SUM_BW-1:0] win_max;
  logic [CNT_BW-2:0]        buf_idx;

  function automatic logic signed [SUM_BW-1:0] smax(
    input logic signed [SUM_BW-1:0] a,
    input logic signed [SUM_BW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign buf_idx  = col_q[CNT_BW-1:1];
  assign pair_max = smax(hold_q, i_y);
  assign win_max  = smax(rowbuf_q[buf_idx], pair_max);

  always_comb begin
    col_d          = col_q;
    row_d          = row_q;
    hold_d         = hold_q;
    o_y_d          = o_y_q;
    o_valid_d      = 1'b0;
    o_frame_done_d = 1'b0;
    rowbuf_we      = 1'b0;

    if (i_valid) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      if (!col_q[0]) begin
        // The left column of a window is kept only until its right neighbour arrives.
        hold_d = i_y;
      end else if (!row_q[0]) begin
        rowbuf_we = 1'b1;
      end else begin
        o_valid_d      = 1'b1;
        o_y_d          = ((RELU_EN != 0) && win_max[SUM_BW-1]) ? '0 : win_max;
        o_frame_done_d = (row_q == LAST) && (col_q == LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q          <= '0;
      row_q          <= '0;
      hold_q         <= '0;
      o_y_q          <= '0;
      o_valid_q      <= 1'b0;
      o_frame_done_q <= 1'b0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      hold_q         <= hold_d;
      o_y_q          <= o_y_d;
      o_valid_q      <= o_valid_d;
      o_frame_done_q <= o_frame_done_d;
    end
  end

  // A write during reset is harmless: entries are always rewritten before they are read.
  always_ff @(posedge clk) begin
    if (rowbuf_we) begin
      rowbuf_q[buf_idx] <= pair_max;
    end
  end

  assign o_y          = o_y_q;
  assign o_valid      = o_valid_q;
  assign o_frame_done = o_frame_done_q;

endmodule
